ctrl_exposure_timer: RTL and testbench
======================================

CTRL_EXPOSURE_TIMER -- requirements
Module: ctrl_exposure_timer

Interface
REQ-001 Parameter EX_MIN, default 2, shortest legal exposure in ticks.
REQ-002 Parameter EX_MAX, default 30, longest legal exposure in ticks.
REQ-003 Parameter EX_PRESCALE, default 4, clock cycles per tick; used only when EX_TIMER_PRESCALE_EN is defined.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port ex_init  input  5  exposure length in ticks, produced by the upstream exposure-time setting counter.
REQ-007 Port ex_start  input  1  request to begin an exposure; sampled each rising edge.
REQ-008 Port ex_abort  input  1  cancel an exposure in progress.
REQ-009 Port ex_busy  output  1  high while an exposure is running.
REQ-010 Port ex_done  output  1  single-cycle pulse on normal completion.
REQ-011 Port ex_count  output  5  remaining ticks of the current exposure.

Function
REQ-012 The FSM shall have exactly three states: IDLE, EXPOSE, DONE.
REQ-013 In IDLE, ex_start=1 with ex_abort=0 shall cause EXPOSE on the next edge, with ex_count loaded with the clamped ex_init.
REQ-014 Clamping: ex_init<EX_MIN loads EX_MIN; ex_init>EX_MAX loads EX_MAX; otherwise ex_init unchanged.
REQ-015 ex_init shall be sampled only at the start edge; later changes shall not affect a running exposure.
REQ-016 In EXPOSE, each tick shall decrement ex_count by 1; no wrap below 0.
REQ-017 A tick with ex_count==1 shall move the FSM to DONE, with ex_count=0; exposure lasts exactly N ticks for loaded value N.
REQ-018 ex_busy shall equal (state==EXPOSE), registered; no combinational path from inputs.
REQ-019 ex_done shall be high exactly during the single cycle in DONE; DONE shall always return to IDLE on the next edge.
REQ-020 ex_start shall be ignored in EXPOSE and DONE; no queueing.
REQ-021 ex_abort=1 in EXPOSE shall force IDLE on the next edge with ex_count=0 and no ex_done pulse.
REQ-022 ex_abort and ex_start both high in IDLE: abort wins, FSM stays IDLE.
REQ-023 ex_abort in DONE shall be ignored; the ex_done pulse still completes.
REQ-024 ex_count shall hold 0 in IDLE and DONE.

Reset
REQ-025 reset=1 shall immediately, without a clock edge, force state=IDLE, ex_count=0, ex_busy=0, ex_done=0, prescaler=0.
REQ-026 Reset asserted mid-exposure shall discard the exposure; no ex_done pulse after release.
REQ-027 The first ex_start after reset release shall be accepted on the first rising edge at which reset is low.

Configuration
REQ-028 Macro EX_TIMER_PRESCALE_EN shall select the tick source.
REQ-029 With EX_TIMER_PRESCALE_EN defined: a tick is one cycle in every EX_PRESCALE cycles; the prescaler clears on the start edge; the first tick occurs EX_PRESCALE cycles after entering EXPOSE.
REQ-030 Without EX_TIMER_PRESCALE_EN: every clock cycle in EXPOSE is a tick; no prescaler logic is synthesised.

Structure
REQ-031 Shared package ctrl_pkg shall hold the state enum (IDLE, EXPOSE, DONE) and the EX_MIN/EX_MAX default constants, reused by the upstream exposure-time counter.
REQ-032 The prescaler shall be sub-module ctrl_tick_gen (clk, reset, clear, tick), instantiated only under EX_TIMER_PRESCALE_EN.

Verification (macro undefined unless stated)
REQ-033 ex_init=5, pulse ex_start -> ex_busy high 5 cycles, ex_count 5,4,3,2,1, then ex_done for 1 cycle, ex_count=0.
REQ-034 ex_init=0, then ex_init=31, each with ex_start -> loads 2, then 30; ex_done after 2 and 30 cycles respectively.
REQ-035 ex_init=10, start, ex_abort at ex_count=6 -> IDLE next edge, ex_count=0, no ex_done; start and abort together in IDLE -> stays IDLE.
REQ-036 ex_init=8, start, change ex_init to 3 and pulse ex_start at ex_count=4 -> exposure finishes after 8 ticks; second start ignored.
REQ-037 Reset asserted between clock edges at ex_count=3 -> all outputs 0 before next edge; no later ex_done.
REQ-038 Macro defined, EX_PRESCALE=4, ex_init=3 -> ex_done after 12 cycles; ex_count decrements every 4th cycle.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared exposure-control definitions: FSM state encoding, exposure
// limits and the exposure clamp helper, also used by the setting counter.
package ctrl_pkg;

  localparam int EX_W       = 5;
  localparam int EX_MIN_DEF = 2;
  localparam int EX_MAX_DEF = 30;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPOSE = 2'd1,
    DONE   = 2'd2
  } ex_state_e;

  // Limit a requested exposure length to the legal range [lo, hi].
  function automatic logic [EX_W-1:0] ex_clamp(
    input logic [EX_W-1:0] v,
    input int              lo,
    input int              hi
  );
    if (int'(v) < lo) return EX_W'(lo);
    if (int'(v) > hi) return EX_W'(hi);
    return v;
  endfunction

endpackage

// File: rtl/ctrl_tick_gen.sv
// Exposure tick prescaler: one-cycle tick every PRESCALE clocks.
// Instantiated only when EX_TIMER_PRESCALE_EN is defined.
module ctrl_tick_gen #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Tick on the last cycle of each prescale period.
  always_comb begin
    tick = (cnt_q == LAST);
  end

  // Restart the period on clear so the first tick lands PRESCALE cycles later.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) cnt_d = '0;
  end

  // Prescale counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ctrl_exposure_timer.sv
// Exposure timer: IDLE/EXPOSE/DONE FSM counting a clamped exposure down.
// Define EX_TIMER_PRESCALE_EN to derive ticks from ctrl_tick_gen.
import ctrl_pkg::*;

module ctrl_exposure_timer #(
  parameter int EX_MIN      = EX_MIN_DEF,
  parameter int EX_MAX      = EX_MAX_DEF,
  parameter int EX_PRESCALE = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [EX_W-1:0] ex_init,
  input  logic            ex_start,
  input  logic            ex_abort,
  output logic            ex_busy,
  output logic            ex_done,
  output logic [EX_W-1:0] ex_count
);

  if (EX_MIN < 1 || EX_MIN > EX_MAX ||
      EX_MAX > (1 << EX_W) - 1 || EX_PRESCALE < 1) begin : g_bad_cfg
    $error("ctrl_exposure_timer: illegal parameter set");
  end

  ex_state_e       state_q;
  ex_state_e       state_d;
  logic [EX_W-1:0] count_q;
  logic [EX_W-1:0] count_d;
  logic            start_ok;
  logic            tick;

  // A start is taken only from IDLE, and abort always wins.
  always_comb begin
    start_ok = (state_q == IDLE) && ex_start && !ex_abort;
  end

`ifdef EX_TIMER_PRESCALE_EN
  ctrl_tick_gen #(
    .PRESCALE (EX_PRESCALE)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clear (start_ok),
    .tick  (tick)
  );
`else
  assign tick = 1'b1;
`endif

  // State and remaining-tick registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next state: ex_init is captured only on the start edge.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (start_ok) begin
          state_d = EXPOSE;
          count_d = ex_clamp(ex_init, EX_MIN, EX_MAX);
        end
      end
      EXPOSE: begin
        if (ex_abort) begin
          state_d = IDLE;
          count_d = '0;
        end else if (tick) begin
          if (count_q <= EX_W'(1)) begin
            state_d = DONE;
            count_d = '0;
          end else begin
            count_d = count_q - EX_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        count_d = '0;
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // Outputs decode registered state only.
  always_comb begin
    ex_busy  = (state_q == EXPOSE);
    ex_done  = (state_q == DONE);
    ex_count = count_q;
  end

endmodule

// File: tb/tb_ctrl_exposure_timer.sv
// Self-checking bench for ctrl_exposure_timer.
// Honours EX_TIMER_PRESCALE_EN when the design is built with it.
module tb_ctrl_exposure_timer;

  localparam int MINV = 2;
  localparam int MAXV = 30;
  localparam int PS   = 4;
`ifdef EX_TIMER_PRESCALE_EN
  localparam int TP = PS;
`else
  localparam int TP = 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ex_init;
  logic       ex_start;
  logic       ex_abort;
  logic       ex_busy;
  logic       ex_done;
  logic [4:0] ex_count;

  int ntests = 0;
  int nfail  = 0;

  ctrl_exposure_timer #(
    .EX_MIN      (MINV),
    .EX_MAX      (MAXV),
    .EX_PRESCALE (PS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ex_init  (ex_init),
    .ex_start (ex_start),
    .ex_abort (ex_abort),
    .ex_busy  (ex_busy),
    .ex_done  (ex_done),
    .ex_count (ex_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int clampv(input int v);
    if (v < MINV) return MINV;
    if (v > MAXV) return MAXV;
    return v;
  endfunction

  // Expected {busy, done, count} while exposing: k cycles into an N-tick run.
  function automatic logic [6:0] expv(input int n, input int k);
    return {1'b1, 1'b0, 5'(n - k / TP)};
  endfunction

  function automatic logic [6:0] outv();
    return {ex_busy, ex_done, ex_count};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] g;
    reset = 1'b1; ex_start = 1'b0; ex_abort = 1'b0; ex_init = '0;
    #3;
    g = outv(); ntests++;
    if (g !== 7'd0) begin
      nfail++; $display("FAIL reset_async got %b want %b", g, 7'd0);
    end
    step(); step();
    @(negedge clk);
    g = outv(); ntests++;
    if (g !== 7'd0) begin
      nfail++; $display("FAIL reset_hold got %b want %b", g, 7'd0);
    end
    step();
    reset = 1'b0; ex_init = 5'd4; ex_start = 1'b1;
    step();
    ex_start = 1'b0;
    for (int k = 0; k < 4 * TP; k++) begin
      @(negedge clk);
      g = outv(); ntests++;
      if (g !== expv(4, k)) begin
        nfail++; $display("FAIL first_start k=%0d got %b want %b", k, g, expv(4, k));
      end
      step();
    end
    @(negedge clk);
    g = outv(); ntests++;
    if (g !== 7'b0100000) begin
      nfail++; $display("FAIL first_done got %b want %b", g, 7'b0100000);
    end
    step();
  endtask

  task automatic test_basic();
    logic [6:0] g;
    ex_init = 5'd5; ex_start = 1'b1;
    step();
    ex_start = 1'b0;
    for (int k = 0; k < 5 * TP; k++) begin
      @(negedge clk);
      g = outv(); ntests++;
      if (g !== expv(5, k)) begin
        nfail++; $display("FAIL basic k=%0d got %b want %b", k, g, expv(5, k));
      end
      step();
    end
    @(negedge clk);
    g = outv(); ntests++;
    if (g !== 7'b0100000) begin
      nfail++; $display("FAIL basic_done got %b want %b", g, 7'b0100000);
    end
    step();
    @(negedge clk);
    g = outv(); ntests++;
    if (g !== 7'd0) begin
      nfail++; $display("FAIL basic_idle got %b want %b", g, 7'd0);
    end
    step();
  endtask

  task automatic test_clamp();
    logic [6:0] g;
    int         n;
    int         reqs [2] = '{0, 31};
    for (int t = 0; t < 2; t++) begin
      n = clampv(reqs[t]);
      ex_init = 5'(reqs[t]); ex_start = 1'b1;
      step();
      ex_start = 1'b0;
      for (int k = 0; k < n * TP; k++) begin
        @(negedge clk);
        g = outv(); ntests++;
        if (g !== expv(n, k)) begin
          nfail++; $display("FAIL clamp init=%0d k=%0d got %b want %b", reqs[t], k, g, expv(n, k));
        end
        step();
      end
      @(negedge clk);
      g = outv(); ntests++;
      if (g !== 7'b0100000) begin
        nfail++; $display("FAIL clamp_done init=%0d got %b want %b", reqs[t], g, 7'b0100000);
      end
      step();
    end
  endtask

  task automatic test_abort();
    logic [6:0] g;
    ex_init = 5'd10; ex_start = 1'b1;
    step();
    ex_start = 1'b0;
    for (int k = 0; k < 10 * TP; k++) begin
      @(negedge clk);
      g = outv(); ntests++;
      if (g !== expv(10, k)) begin
        nfail++; $display("FAIL abort_run k=%0d got %b want %b", k, g, expv(10, k));
      end
      if (10 - k / TP == 6) begin
        ex_abort = 1'b1;
        step();
        ex_abort = 1'b0;
        break;
      end
      step();
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      g = outv(); ntests++;
      if (g !== 7'd0) begin
        nfail++; $display("FAIL abort_idle k=%0d got %b want %b", k, g, 7'd0);
      end
      step();
    end
    ex_init = 5'd7; ex_start = 1'b1; ex_abort = 1'b1;
    step();
    ex_start = 1'b0; ex_abort = 1'b0;
    @(negedge clk);
    g = outv(); ntests++;
    if (g !== 7'd0) begin
      nfail++; $display("FAIL start_abort_idle got %b want %b", g, 7'd0);
    end
    step();
  endtask

  task automatic test_ignore_start();
    logic [6:0] g;
    ex_init = 5'd8; ex_start = 1'b1;
    step();
    ex_start = 1'b0;
    for (int k = 0; k < 8 * TP; k++) begin
      @(negedge clk);
      g = outv(); ntests++;
      if (g !== expv(8, k)) begin
        nfail++; $display("FAIL ignore_run k=%0d got %b want %b", k, g, expv(8, k));
      end
      if (8 - k / TP == 4 && k % TP == 0) begin
        ex_init = 5'd3; ex_start = 1'b1;
      end else begin
        ex_start = 1'b0;
      end
      step();
    end
    @(negedge clk);
    g = outv(); ntests++;
    if (g !== 7'b0100000) begin
      nfail++; $display("FAIL ignore_done got %b want %b", g, 7'b0100000);
    end
    ex_start = 1'b1;
    step();
    ex_start = 1'b0;
    @(negedge clk);
    g = outv(); ntests++;
    if (g !== 7'd0) begin
      nfail++; $display("FAIL ignore_no_queue got %b want %b", g, 7'd0);
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic [6:0] g;
    int         seen_done = 0;
    ex_init = 5'd5; ex_start = 1'b1;
    step();
    ex_start = 1'b0;
    for (int k = 0; k < 5 * TP; k++) begin
      @(negedge clk);
      if (5 - k / TP == 3) break;
      step();
    end
    g = outv(); ntests++;
    if (g !== 7'b1000011) begin
      nfail++; $display("FAIL rst_mid_pre got %b want %b", g, 7'b1000011);
    end
    #1 reset = 1'b1;
    #1;
    g = outv(); ntests++;
    if (g !== 7'd0) begin
      nfail++; $display("FAIL rst_mid_async got %b want %b", g, 7'd0);
    end
    step();
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ex_done || ex_busy) seen_done++;
      step();
    end
    ntests++;
    if (seen_done != 0) begin
      nfail++; $display("FAIL rst_mid_after got %0d active cycles want 0", seen_done);
    end
  endtask

  task automatic test_random();
    logic [6:0] g;
    int         n;
    int         ab;
    int         gap;
    bit         aborted;
    for (int t = 0; t < 40; t++) begin
      gap = $urandom_range(0, 2);
      for (int i = 0; i < gap; i++) begin
        ex_start = 1'($urandom_range(0, 1)); ex_abort = 1'b1;
        ex_init = 5'($urandom_range(0, 31));
        step();
        @(negedge clk);
        g = outv(); ntests++;
        if (g !== 7'd0) begin
          nfail++; $display("FAIL rnd_gap t=%0d got %b want %b", t, g, 7'd0);
        end
      end
      ex_init = 5'($urandom_range(0, 31));
      n = clampv(int'(ex_init));
      ex_start = 1'b1; ex_abort = 1'b0;
      step();
      ex_start = 1'b0;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n * TP - 1)) : -1;
      aborted = 1'b0;
      for (int k = 0; k < n * TP; k++) begin
        @(negedge clk);
        g = outv(); ntests++;
        if (g !== expv(n, k)) begin
          nfail++; $display("FAIL rnd_run t=%0d k=%0d got %b want %b", t, k, g, expv(n, k));
        end
        ex_start = 1'($urandom_range(0, 1));
        ex_init  = 5'($urandom_range(0, 31));
        ex_abort = (k == ab);
        step();
        if (k == ab) begin
          aborted = 1'b1;
          break;
        end
      end
      ex_start = 1'b0; ex_abort = 1'b0;
      @(negedge clk);
      g = outv(); ntests++;
      if (g !== (aborted ? 7'd0 : 7'b0100000)) begin
        nfail++; $display("FAIL rnd_end t=%0d abort=%0d got %b", t, aborted, g);
      end
      ex_abort = 1'($urandom_range(0, 1));
      step();
      ex_abort = 1'b0;
      @(negedge clk);
      g = outv(); ntests++;
      if (g !== 7'd0) begin
        nfail++; $display("FAIL rnd_idle t=%0d got %b want %b", t, g, 7'd0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_abort();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
